// File: rtl/latch_bank_arbiter.sv
// Two-port round-robin arbiter and sequencer for the SR-latch word bank.
// Serialises A/B requests and stretches each write pulse so the latches settle.
module latch_bank_arbiter #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 2,
    parameter int WR_PULSE = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [WIDTH-1:0]  wdata_a,
    output logic              gnt_a,
    output logic              done_a,
    output logic              rvalid_a,
    output logic [WIDTH-1:0]  rdata_a,

    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [WIDTH-1:0]  wdata_b,
    output logic              gnt_b,
    output logic              done_b,
    output logic              rvalid_b,
    output logic [WIDTH-1:0]  rdata_b,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_sel,
    output logic [WIDTH-1:0]  mem_din,
    input  logic [WIDTH-1:0]  mem_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    localparam logic [3:0] PULSE_LAST = 4'(WR_PULSE - 1);

    state_t            r_state;
    state_t            w_state_nx;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_nx;
    logic              r_ptr;
    logic              w_ptr_nx;
    logic              r_owner;
    logic              w_owner_nx;

    logic              r_gnt_a,    w_gnt_a_nx;
    logic              r_gnt_b,    w_gnt_b_nx;
    logic              r_done_a,   w_done_a_nx;
    logic              r_done_b,   w_done_b_nx;
    logic              r_rvalid_a, w_rvalid_a_nx;
    logic              r_rvalid_b, w_rvalid_b_nx;
    logic [WIDTH-1:0]  r_rdata_a,  w_rdata_a_nx;
    logic [WIDTH-1:0]  r_rdata_b,  w_rdata_b_nx;
    logic              r_mem_we,   w_mem_we_nx;
    logic [ADDR_W-1:0] r_mem_sel,  w_mem_sel_nx;
    logic [WIDTH-1:0]  r_mem_din,  w_mem_din_nx;

    logic              w_any_req;
    logic              w_win_b;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_win_addr;
    logic [WIDTH-1:0]  w_win_wdata;

    // r_ptr is the preferred port on a tie: 0 = A, 1 = B
    assign w_any_req   = req_a | req_b;
    assign w_win_b     = req_b & (~req_a | r_ptr);
    assign w_win_we    = w_win_b ? we_b    : we_a;
    assign w_win_addr  = w_win_b ? addr_b  : addr_a;
    assign w_win_wdata = w_win_b ? wdata_b : wdata_a;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ptr      <= 1'b0;
            r_owner    <= 1'b0;
            r_gnt_a    <= 1'b0;
            r_gnt_b    <= 1'b0;
            r_done_a   <= 1'b0;
            r_done_b   <= 1'b0;
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
            r_rdata_a  <= '0;
            r_rdata_b  <= '0;
            r_mem_we   <= 1'b0;
            r_mem_sel  <= '0;
            r_mem_din  <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_ptr      <= w_ptr_nx;
            r_owner    <= w_owner_nx;
            r_gnt_a    <= w_gnt_a_nx;
            r_gnt_b    <= w_gnt_b_nx;
            r_done_a   <= w_done_a_nx;
            r_done_b   <= w_done_b_nx;
            r_rvalid_a <= w_rvalid_a_nx;
            r_rvalid_b <= w_rvalid_b_nx;
            r_rdata_a  <= w_rdata_a_nx;
            r_rdata_b  <= w_rdata_b_nx;
            r_mem_we   <= w_mem_we_nx;
            r_mem_sel  <= w_mem_sel_nx;
            r_mem_din  <= w_mem_din_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_ptr_nx      = r_ptr;
        w_owner_nx    = r_owner;
        w_gnt_a_nx    = 1'b0;
        w_gnt_b_nx    = 1'b0;
        w_done_a_nx   = 1'b0;
        w_done_b_nx   = 1'b0;
        w_rvalid_a_nx = 1'b0;
        w_rvalid_b_nx = 1'b0;
        w_rdata_a_nx  = r_rdata_a;
        w_rdata_b_nx  = r_rdata_b;
        w_mem_we_nx   = 1'b0;
        w_mem_sel_nx  = r_mem_sel;
        w_mem_din_nx  = r_mem_din;

        unique case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_owner_nx   = w_win_b;
                    w_gnt_a_nx   = ~w_win_b;
                    w_gnt_b_nx   = w_win_b;
                    w_mem_sel_nx = w_win_addr;
                    w_mem_din_nx = w_win_wdata;
                    if (w_win_we) begin
                        w_state_nx  = WRITE;
                        w_mem_we_nx = 1'b1;
                        w_cnt_nx    = PULSE_LAST;
                    end else begin
                        w_state_nx  = READ;
                    end
                end
            end
            WRITE: begin
                if (r_cnt == 4'd0) begin
                    w_state_nx  = IDLE;
                    w_done_a_nx = ~r_owner;
                    w_done_b_nx = r_owner;
                    w_ptr_nx    = ~r_owner;
                end else begin
                    w_cnt_nx    = r_cnt - 4'd1;
                    w_mem_we_nx = 1'b1;
                end
            end
            READ: begin
                // mem_sel has been stable for the whole READ cycle here
                w_state_nx = IDLE;
                w_ptr_nx   = ~r_owner;
                if (r_owner) begin
                    w_rvalid_b_nx = 1'b1;
                    w_rdata_b_nx  = mem_dout;
                end else begin
                    w_rvalid_a_nx = 1'b1;
                    w_rdata_a_nx  = mem_dout;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    assign gnt_a    = r_gnt_a;
    assign gnt_b    = r_gnt_b;
    assign done_a   = r_done_a;
    assign done_b   = r_done_b;
    assign rvalid_a = r_rvalid_a;
    assign rvalid_b = r_rvalid_b;
    assign rdata_a  = r_rdata_a;
    assign rdata_b  = r_rdata_b;
    assign mem_we   = r_mem_we;
    assign mem_sel  = r_mem_sel;
    assign mem_din  = r_mem_din;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed bench for latch_bank_arbiter with a behavioural 4x8 latch bank.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_latch_bank_arbiter;

    logic       clk;
    logic       rst;
    logic       req_a, we_a, req_b, we_b;
    logic [1:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;
    logic       gnt_a, done_a, rvalid_a;
    logic       gnt_b, done_b, rvalid_b;
    logic [7:0] rdata_a, rdata_b;
    logic       mem_we;
    logic [1:0] mem_sel;
    logic [7:0] mem_din, mem_dout;

    int n_chk;
    int n_err;

    logic [7:0] bank [4];
    logic       bank_clr;

    latch_bank_arbiter #(.WIDTH(8), .ADDR_W(2), .WR_PULSE(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .we_a     (we_a),
        .addr_a   (addr_a),
        .wdata_a  (wdata_a),
        .gnt_a    (gnt_a),
        .done_a   (done_a),
        .rvalid_a (rvalid_a),
        .rdata_a  (rdata_a),
        .req_b    (req_b),
        .we_b     (we_b),
        .addr_b   (addr_b),
        .wdata_b  (wdata_b),
        .gnt_b    (gnt_b),
        .done_b   (done_b),
        .rvalid_b (rvalid_b),
        .rdata_b  (rdata_b),
        .mem_we   (mem_we),
        .mem_sel  (mem_sel),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bank_clr) begin
            for (int i = 0; i < 4; i++) bank[i] <= 8'h00;
        end else if (mem_we) begin
            bank[mem_sel] <= mem_din;
        end
    end
    assign mem_dout = bank[mem_sel];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        rst      = 1'b0;
        bank_clr = 1'b1;
        req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
        req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
        #1;
        do_reset();
        bank_clr = 1'b0;
        check("rst_state", {gnt_a, gnt_b, done_a, done_b,
                            rvalid_a, rvalid_b, mem_we}, 0);
        check("rst_data", {rdata_a, rdata_b, mem_din, 6'd0, mem_sel}, 0);

        // 1: A writes A5 to word 2
        req_a = 1; we_a = 1; addr_a = 2; wdata_a = 8'hA5;
        tick();
        check("t1_gnt", {gnt_a, gnt_b, mem_we}, 3'b101);
        check("t1_sel_din", {mem_sel, mem_din}, {2'd2, 8'hA5});
        req_a = 0;
        tick();
        check("t1_pulse2", {gnt_a, mem_we, done_a}, 3'b010);
        check("t1_stable", {mem_sel, mem_din}, {2'd2, 8'hA5});
        tick();
        check("t1_done", {done_a, done_b, mem_we}, 3'b100);
        check("t1_bank2", bank[2], 8'hA5);

        // 2: B reads word 2
        req_b = 1; we_b = 0; addr_b = 2;
        tick();
        check("t2_gnt", {gnt_b, gnt_a, mem_we, done_a}, 4'b1000);
        check("t2_sel", mem_sel, 2);
        req_b = 0;
        tick();
        check("t2_rvalid", {rvalid_b, rvalid_a}, 2'b10);
        check("t2_rdata", rdata_b, 8'hA5);
        tick();
        check("t2_hold", {rvalid_b, rdata_b}, {1'b0, 8'hA5});

        // 3: simultaneous requests after reset
        do_reset();
        req_a = 1; we_a = 1; addr_a = 1; wdata_a = 8'h5A;
        req_b = 1; we_b = 0; addr_b = 1;
        tick();
        check("t3_first", {gnt_a, gnt_b}, 2'b10);
        req_a = 0;
        tick();
        check("t3_wait", {gnt_b, done_a}, 2'b00);
        tick();
        check("t3_done_a", {done_a, gnt_b}, 2'b10);
        tick();
        check("t3_gnt_b", {gnt_b, gnt_a, mem_sel}, {2'b10, 2'd1});
        req_b = 0;
        tick();
        check("t3_rd_b", {rvalid_b, rdata_b}, {1'b1, 8'h5A});
        req_a = 1; we_a = 1; addr_a = 3; wdata_a = 8'h77;
        req_b = 1; we_b = 1; addr_b = 0; wdata_b = 8'h99;
        tick();
        check("t3_pair2", {gnt_a, gnt_b}, 2'b10);
        req_a = 0;
        tick();
        tick();
        check("t3_done_a2", {done_a, gnt_b}, 2'b10);
        tick();
        check("t3_gnt_b2", {gnt_b, mem_sel, mem_din}, {1'b1, 2'd0, 8'h99});
        req_b = 0;
        tick();
        tick();
        check("t3_done_b2", {done_b, done_a}, 2'b10);

        // 4: A holds req for three writes
        bank_clr = 1'b1;
        do_reset();
        bank_clr = 1'b0;
        req_a = 1; we_a = 1; addr_a = 0; wdata_a = 8'h11;
        tick();
        check("t4_g1", gnt_a, 1);
        addr_a = 1; wdata_a = 8'h22;
        tick();
        check("t4_ign", {gnt_a, done_a}, 2'b00);
        tick();
        check("t4_d1", {gnt_a, done_a}, 2'b01);
        tick();
        check("t4_g2", {gnt_a, mem_sel, mem_din}, {1'b1, 2'd1, 8'h22});
        addr_a = 3; wdata_a = 8'h33;
        tick();
        tick();
        check("t4_d2", done_a, 1);
        tick();
        check("t4_g3", {gnt_a, mem_sel, mem_din}, {1'b1, 2'd3, 8'h33});
        req_a = 0;
        tick();
        tick();
        check("t4_d3", done_a, 1);
        tick();
        check("t4_idle", {gnt_a, done_a, mem_we}, 3'b000);
        check("t4_bank", {bank[0], bank[1], bank[2], bank[3]},
              32'h1122_0033);

        // 5: reset in the second WRITE cycle
        req_a = 1; we_a = 1; addr_a = 2; wdata_a = 8'hC3;
        tick();
        check("t5_gnt", {gnt_a, mem_we}, 2'b11);
        req_a = 0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_abort", {mem_we, gnt_a, gnt_b, done_a, done_b,
                           rvalid_a, rvalid_b}, 0);
        tick();
        check("t5_nodone", {done_a, mem_we}, 2'b00);
        req_a = 1; we_a = 0; addr_a = 1;
        tick();
        check("t5_rgnt", {gnt_a, mem_sel}, {1'b1, 2'd1});
        req_a = 0;
        tick();
        check("t5_rd", {rvalid_a, rdata_a}, {1'b1, 8'h22});

        // 6: read data ownership per port
        req_b = 1; we_b = 0; addr_b = 3;
        tick();
        check("t6_gnt_b", gnt_b, 1);
        req_b = 0;
        tick();
        check("t6_rd_b", {rvalid_b, rvalid_a, rdata_b}, {2'b10, 8'h33});
        check("t6_a_keep", rdata_a, 8'h22);
        req_a = 1; we_a = 1; addr_a = 0; wdata_a = 8'h44;
        tick();
        req_a = 0;
        tick();
        tick();
        check("t6_done_a", done_a, 1);
        check("t6_keep", {rdata_a, rdata_b}, {8'h22, 8'h33});
        check("t6_bank0", bank[0], 8'h44);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
